// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core types and constants
package ooo_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int ROB_PREG_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  is_store;
    logic                  mispredict;
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic [5:0]            Ard;
    logic [ROB_PREG_W-1:0] Prd;
    logic [ROB_PREG_W-1:0] old_Prd;
    logic [31:0]           data;
    logic [31:0]           target;
    logic [31:0]           addr;
    logic [3:0]            mask;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with commit-time mispredict flush
module reorder_buffer
  import ooo_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PREG_W = ROB_PREG_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dis_valid,
  output logic              dis_ready,
  input  logic [31:0]       dis_pc,
  input  logic [31:0]       dis_inst,
  input  logic [5:0]        dis_Ard,
  input  logic [PREG_W-1:0] dis_Prd,
  input  logic [PREG_W-1:0] dis_old_Prd,
  input  logic              dis_is_store,
  output logic [IDX_W-1:0]  dis_rob_idx,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rob_idx,
  input  logic [31:0]       wb_data,
  input  logic              wb_mispredict,
  input  logic [31:0]       wb_target,
  input  logic              st_wb_valid,
  input  logic [IDX_W-1:0]  st_wb_rob_idx,
  input  logic [31:0]       st_wb_addr,
  input  logic [31:0]       st_wb_data,
  input  logic [3:0]        st_wb_mask,
  input  logic              st_commit_ready,
  output logic              commit_valid,
  output logic [31:0]       commit_pc,
  output logic [31:0]       commit_inst,
  output logic [5:0]        commit_Ard,
  output logic [PREG_W-1:0] commit_Prd,
  output logic [PREG_W-1:0] commit_old_Prd,
  output logic [31:0]       commit_data,
  output logic              st_commit,
  output logic [31:0]       st_addr,
  output logic [31:0]       st_data,
  output logic [3:0]        st_mask,
  output logic              flush_valid,
  output logic [31:0]       flush_pc
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  rob_entry_t       entries [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  rob_entry_t head_e;
  rob_entry_t new_entry;
  logic       dis_fire;
  logic       wb_hit;
  logic       st_hit;

  assign head_e = entries[head];

  assign commit_valid = head_e.valid && head_e.done && (!head_e.is_store || st_commit_ready);
  assign flush_valid  = commit_valid && head_e.mispredict;
  assign dis_ready    = (count != FULL_COUNT) && !flush_valid;
  assign dis_fire     = dis_valid && dis_ready;
  assign dis_rob_idx  = tail;

  // A store writeback to the same slot supersedes the execution result.
  assign st_hit = st_wb_valid && entries[st_wb_rob_idx].valid;
  assign wb_hit = wb_valid && entries[wb_rob_idx].valid && !(st_hit && (st_wb_rob_idx == wb_rob_idx));

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.is_store = dis_is_store;
    new_entry.pc       = dis_pc;
    new_entry.inst     = dis_inst;
    new_entry.Ard      = dis_Ard;
    new_entry.Prd      = dis_Prd;
    new_entry.old_Prd  = dis_old_Prd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush_valid) begin
      // Retiring branch empties the buffer; younger results and dispatch are discarded.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= head + 1'b1;
      tail  <= head + 1'b1;
      count <= '0;
    end else begin
      if (wb_hit) begin
        entries[wb_rob_idx].done       <= 1'b1;
        entries[wb_rob_idx].data       <= wb_data;
        entries[wb_rob_idx].mispredict <= wb_mispredict;
        entries[wb_rob_idx].target     <= wb_target;
      end
      if (st_hit) begin
        entries[st_wb_rob_idx].done <= 1'b1;
        entries[st_wb_rob_idx].data <= st_wb_data;
        entries[st_wb_rob_idx].addr <= st_wb_addr;
        entries[st_wb_rob_idx].mask <= st_wb_mask;
      end
      if (commit_valid) begin
        entries[head] <= '0;
        head          <= head + 1'b1;
      end
      if (dis_fire) begin
        entries[tail] <= new_entry;
        tail          <= tail + 1'b1;
      end
      count <= count + (IDX_W+1)'(dis_fire) - (IDX_W+1)'(commit_valid);
    end
  end

  assign commit_pc      = commit_valid ? head_e.pc      : '0;
  assign commit_inst    = commit_valid ? head_e.inst    : '0;
  assign commit_Ard     = commit_valid ? head_e.Ard     : '0;
  assign commit_Prd     = commit_valid ? head_e.Prd     : '0;
  assign commit_old_Prd = commit_valid ? head_e.old_Prd : '0;
  assign commit_data    = commit_valid ? head_e.data    : '0;
  assign st_commit      = commit_valid && head_e.is_store;
  assign st_addr        = st_commit ? head_e.addr : '0;
  assign st_data        = st_commit ? head_e.data : '0;
  assign st_mask        = st_commit ? head_e.mask : '0;
  assign flush_pc       = flush_valid ? head_e.target : '0;

endmodule
